// File: rtl/zr_soc_pkg.sv
// Shared SoC types and the coreplex data-slave address map.
package zr_soc_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  localparam addr_t TCM_BASE = 32'h8000_0000;
  localparam addr_t TCM_MASK = 32'h0000_3fff;
  localparam addr_t DM_BASE  = 32'h0000_0000;
  localparam addr_t DM_MASK  = 32'h0000_3fff;
  localparam addr_t DTM_BASE = 32'h0000_4000;
  localparam addr_t DTM_MASK = 32'h0000_0fff;

endpackage

// File: rtl/zr_id_fifo.sv
// Small synchronous FIFO of target ids; exposes both head and most recently written (tail) entry.
module zr_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_head,
  output logic [WIDTH-1:0]           o_tail,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;
  logic [PW-1:0]    w_tail_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_wr       = i_push && !o_full;
  assign w_rd       = i_pop && !o_empty;
  assign w_tail_idx = (r_wr_ptr == '0) ? LAST : r_wr_ptr - PW'(1);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_tail     = r_mem[w_tail_idx];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/zr_dbus_demux.sv
// LSU data-bus demux: address decode, per-slave request steering, in-order response return
// and a synthetic error response for unmapped addresses.
module zr_dbus_demux
  import zr_soc_pkg::*;
#(
  parameter int                         N_SLAVES  = 3,
  parameter int                         MAX_OUTST = 2,
  parameter logic [N_SLAVES-1:0][31:0]  SLV_BASE  = {DTM_BASE, DM_BASE, TCM_BASE},
  parameter logic [N_SLAVES-1:0][31:0]  SLV_MASK  = {DTM_MASK, DM_MASK, TCM_MASK}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m_req_i,
  output logic                     m_gnt_o,
  output logic                     m_rvalid_o,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  addr_t                    m_addr_i,
  input  data_t                    m_wdata_i,
  output data_t                    m_rdata_o,
  output logic                     m_err_o,
  output logic [N_SLAVES-1:0]      s_req_o,
  input  logic [N_SLAVES-1:0]      s_gnt_i,
  input  logic [N_SLAVES-1:0]      s_rvalid_i,
  input  logic [N_SLAVES*32-1:0]   s_rdata_i,
  input  logic [N_SLAVES-1:0]      s_err_i,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output addr_t                    s_addr_o,
  output data_t                    s_wdata_o,
  output logic                     proto_err_o
);

  localparam int IDW = $clog2(N_SLAVES + 1);
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam logic [IDW-1:0] DECERR_ID = IDW'(N_SLAVES);

  logic [IDW-1:0] w_target, w_head, w_tail;
  logic           w_full, w_empty;
  logic [CW-1:0]  w_count;
  logic           w_issue, w_push, w_pop, w_drain, w_head_dec, w_stray;
  logic           w_rvalid, w_err;
  data_t          w_rdata;
  logic           r_decerr_pend, r_proto_err;

  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;

  // Descending scan so the lowest matching index wins on overlapping windows.
  always_comb begin
    w_target = DECERR_ID;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr_i & ~SLV_MASK[i]) == (SLV_BASE[i] & ~SLV_MASK[i])) w_target = IDW'(i);
    end
  end

  always_comb begin
    w_head_dec = !w_empty && (w_head == DECERR_ID);
    w_rvalid   = 1'b0;
    w_err      = 1'b0;
    w_rdata    = '0;
    w_stray    = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (!w_empty && (w_head == IDW'(i))) begin
        w_rvalid = s_rvalid_i[i];
        if (s_rvalid_i[i]) begin
          w_err   = s_err_i[i];
          w_rdata = s_rdata_i[i*32 +: 32];
        end
      end else if (s_rvalid_i[i]) begin
        w_stray = 1'b1;
      end
    end
    if (w_head_dec) begin
      w_rvalid = r_decerr_pend;
      w_err    = r_decerr_pend;
    end
  end

  assign w_pop       = w_rvalid;
  assign m_rvalid_o  = w_rvalid;
  assign m_err_o     = w_err;
  assign m_rdata_o   = w_rdata;
  assign proto_err_o = r_proto_err;

  // A response retiring the only outstanding entry lets a different target issue in the same cycle.
  assign w_drain = (w_count == CW'(1)) && w_pop;
  assign w_issue = rst_n && m_req_i && !w_full && (w_empty || (w_target == w_tail) || w_drain);

  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (w_issue) begin
      if (w_target == DECERR_ID) begin
        m_gnt_o = 1'b1;
      end else begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if (w_target == IDW'(i)) begin
            s_req_o[i] = 1'b1;
            m_gnt_o    = s_gnt_i[i];
          end
        end
      end
    end
  end

  assign w_push = m_gnt_o;

  zr_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTST)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_target),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decerr_pend <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_stray) r_proto_err <= 1'b1;
      if (w_push && (w_target == DECERR_ID)) r_decerr_pend <= 1'b1;
      else if (w_pop && w_head_dec && (w_count == CW'(1))) r_decerr_pend <= 1'b0;
    end
  end

endmodule
